// File: rtl/rs_pkg.sv
// Shared types and widths for the ALU reservation station.
// Tags index the ROB; the all-ones tag means the value is already present.
package rs_pkg;
  localparam int RS_ENTRY_NUM  = 4;
  localparam int ROB_ENTRY_NUM = 8;
  localparam int COMMON_WIDTH  = 32;
  localparam int OP_WIDTH      = 6;
  localparam int TAG_WIDTH     = $clog2(ROB_ENTRY_NUM) + 1;
  localparam int ROB_IDX_WIDTH = TAG_WIDTH - 1;
  localparam int CNT_WIDTH     = $clog2(RS_ENTRY_NUM) + 1;

  localparam logic [TAG_WIDTH-1:0] TAG_INVALID = '1;

  typedef struct packed {
    logic                    rdy;
    logic [TAG_WIDTH-1:0]    tag;
    logic [COMMON_WIDTH-1:0] val;
  } rs_operand_t;

  typedef struct packed {
    logic                 valid;
    logic [OP_WIDTH-1:0]  op;
    logic [TAG_WIDTH-1:0] tag;
    rs_operand_t          src1;
    rs_operand_t          src2;
  } rs_entry_t;
endpackage

// File: rtl/rs_operand_wakeup.sv
// Resolves one operand against the ALU result bus and ROB broadcast.
// Priority: already present, result bus, then ROB.
module rs_operand_wakeup
  import rs_pkg::*;
(
  input  logic                                  cur_rdy,
  input  logic [TAG_WIDTH-1:0]                  cur_tag,
  input  logic [COMMON_WIDTH-1:0]               cur_val,
  input  logic [TAG_WIDTH-1:0]                  res_target,
  input  logic [COMMON_WIDTH-1:0]               res_result,
  input  logic [ROB_ENTRY_NUM-1:0]              rob_valid,
  input  logic [ROB_ENTRY_NUM-1:0]              rob_ready,
  input  logic [ROB_ENTRY_NUM*COMMON_WIDTH-1:0] rob_val,
  output logic                                  nxt_rdy,
  output logic [COMMON_WIDTH-1:0]               nxt_val
);
  logic                    rob_hit;
  logic [COMMON_WIDTH-1:0] rob_sel;

  always_comb begin
    rob_hit = 1'b0;
    rob_sel = '0;
    for (int i = 0; i < ROB_ENTRY_NUM; i++) begin
      if (cur_tag[ROB_IDX_WIDTH-1:0] == ROB_IDX_WIDTH'(i)) begin
        rob_hit = rob_valid[i] && rob_ready[i];
        rob_sel = rob_val[i*COMMON_WIDTH +: COMMON_WIDTH];
      end
    end
    nxt_rdy = 1'b1;
    nxt_val = cur_val;
    // A pending tag is never all-ones, so an idle result bus cannot match
    if (!cur_rdy && cur_tag != TAG_INVALID) begin
      if (res_target == cur_tag) begin
        nxt_val = res_result;
      end else if (rob_hit) begin
        nxt_val = rob_sel;
      end else begin
        nxt_rdy = 1'b0;
      end
    end
  end
endmodule

// File: rtl/alu_rs.sv
// ALU reservation station: collapsing queue, oldest-ready issue.
// Operands wake from the result bus or ROB broadcast every cycle.
module alu_rs
  import rs_pkg::*;
(
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  flush,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [OP_WIDTH-1:0]                   in_op,
  input  logic [TAG_WIDTH-1:0]                  in_tag,
  input  logic [TAG_WIDTH-1:0]                  in_src1_tag,
  input  logic [TAG_WIDTH-1:0]                  in_src2_tag,
  input  logic [COMMON_WIDTH-1:0]               in_src1_val,
  input  logic [COMMON_WIDTH-1:0]               in_src2_val,
  input  logic [ROB_ENTRY_NUM-1:0]              rob_valid,
  input  logic [ROB_ENTRY_NUM-1:0]              rob_ready,
  input  logic [ROB_ENTRY_NUM*COMMON_WIDTH-1:0] rob_val,
  input  logic [TAG_WIDTH-1:0]                  res_target,
  input  logic [COMMON_WIDTH-1:0]               res_result,
  output logic                                  issue_valid,
  input  logic                                  issue_ready,
  output logic [OP_WIDTH-1:0]                   issue_op,
  output logic [COMMON_WIDTH-1:0]               issue_a,
  output logic [COMMON_WIDTH-1:0]               issue_b,
  output logic [TAG_WIDTH-1:0]                  issue_tag,
  output logic [CNT_WIDTH-1:0]                  count
);
  rs_entry_t q    [RS_ENTRY_NUM];
  rs_entry_t nxt  [RS_ENTRY_NUM];
  rs_entry_t woke [RS_ENTRY_NUM+1];
  rs_entry_t new_entry;

  logic [RS_ENTRY_NUM-1:0] w1_rdy, w2_rdy, rdy_vec;
  logic [COMMON_WIDTH-1:0] w1_val [RS_ENTRY_NUM];
  logic [COMMON_WIDTH-1:0] w2_val [RS_ENTRY_NUM];
  logic                    a1_rdy, a2_rdy;
  logic [COMMON_WIDTH-1:0] a1_val, a2_val;

  logic                    any_rdy, issue_load, remove, accept;
  logic [CNT_WIDTH-1:0]    sel, wr_idx, count_nxt;
  logic [OP_WIDTH-1:0]     iss_op;
  logic [TAG_WIDTH-1:0]    iss_tag;
  logic [COMMON_WIDTH-1:0] iss_a, iss_b;

  rs_operand_wakeup u_acc1 (
    .cur_rdy(1'b0), .cur_tag(in_src1_tag), .cur_val(in_src1_val),
    .res_target, .res_result, .rob_valid, .rob_ready, .rob_val,
    .nxt_rdy(a1_rdy), .nxt_val(a1_val)
  );

  rs_operand_wakeup u_acc2 (
    .cur_rdy(1'b0), .cur_tag(in_src2_tag), .cur_val(in_src2_val),
    .res_target, .res_result, .rob_valid, .rob_ready, .rob_val,
    .nxt_rdy(a2_rdy), .nxt_val(a2_val)
  );

  for (genvar g = 0; g < RS_ENTRY_NUM; g++) begin : g_wake
    rs_operand_wakeup u_w1 (
      .cur_rdy(q[g].src1.rdy), .cur_tag(q[g].src1.tag),
      .cur_val(q[g].src1.val),
      .res_target, .res_result, .rob_valid, .rob_ready, .rob_val,
      .nxt_rdy(w1_rdy[g]), .nxt_val(w1_val[g])
    );
    rs_operand_wakeup u_w2 (
      .cur_rdy(q[g].src2.rdy), .cur_tag(q[g].src2.tag),
      .cur_val(q[g].src2.val),
      .res_target, .res_result, .rob_valid, .rob_ready, .rob_val,
      .nxt_rdy(w2_rdy[g]), .nxt_val(w2_val[g])
    );
  end

  assign in_ready   = (count < CNT_WIDTH'(RS_ENTRY_NUM)) && !flush;
  assign issue_load = !issue_valid || issue_ready;
  assign accept     = in_valid && in_ready;
  assign remove     = issue_load && any_rdy;
  assign wr_idx     = count - CNT_WIDTH'(remove);
  assign count_nxt  = count + CNT_WIDTH'(accept) - CNT_WIDTH'(remove);

  always_comb begin
    new_entry.valid     = 1'b1;
    new_entry.op        = in_op;
    new_entry.tag       = in_tag;
    new_entry.src1.rdy  = a1_rdy;
    new_entry.src1.tag  = in_src1_tag;
    new_entry.src1.val  = a1_val;
    new_entry.src2.rdy  = a2_rdy;
    new_entry.src2.tag  = in_src2_tag;
    new_entry.src2.val  = a2_val;
    woke[RS_ENTRY_NUM]  = '0;
    any_rdy = 1'b0;
    sel     = '0;
    iss_op  = '0;
    iss_tag = TAG_INVALID;
    iss_a   = '0;
    iss_b   = '0;
    for (int i = 0; i < RS_ENTRY_NUM; i++) begin
      woke[i]          = q[i];
      woke[i].src1.rdy = w1_rdy[i];
      woke[i].src1.val = w1_val[i];
      woke[i].src2.rdy = w2_rdy[i];
      woke[i].src2.val = w2_val[i];
      rdy_vec[i] = q[i].valid && q[i].src1.rdy && q[i].src2.rdy;
    end
    // Descending scan so the oldest ready entry wins
    for (int i = RS_ENTRY_NUM - 1; i >= 0; i--) begin
      if (rdy_vec[i]) begin
        any_rdy = 1'b1;
        sel     = CNT_WIDTH'(i);
        iss_op  = q[i].op;
        iss_tag = q[i].tag;
        iss_a   = q[i].src1.val;
        iss_b   = q[i].src2.val;
      end
    end
    for (int i = 0; i < RS_ENTRY_NUM; i++) begin
      if (remove && CNT_WIDTH'(i) >= sel) nxt[i] = woke[i+1];
      else nxt[i] = woke[i];
      if (accept && CNT_WIDTH'(i) == wr_idx) nxt[i] = new_entry;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q           <= '{default: '0};
      count       <= '0;
      issue_valid <= 1'b0;
      issue_op    <= '0;
      issue_a     <= '0;
      issue_b     <= '0;
      issue_tag   <= TAG_INVALID;
    end else if (flush) begin
      q           <= '{default: '0};
      count       <= '0;
      issue_valid <= 1'b0;
    end else begin
      q     <= nxt;
      count <= count_nxt;
      if (issue_load) begin
        issue_valid <= any_rdy;
        if (any_rdy) begin
          issue_op  <= iss_op;
          issue_a   <= iss_a;
          issue_b   <= iss_b;
          issue_tag <= iss_tag;
        end
      end
    end
  end
endmodule

// File: tb/tb_alu_rs.sv
// Directed bench for alu_rs: accept, wakeup, ordering, stall, flush.
// Expected values are hand-computed per vector.
module tb_alu_rs;
  import rs_pkg::*;

  logic                                  clk = 1'b0;
  logic                                  rst, flush, in_valid, in_ready;
  logic [OP_WIDTH-1:0]                   in_op;
  logic [TAG_WIDTH-1:0]                  in_tag, in_src1_tag, in_src2_tag;
  logic [COMMON_WIDTH-1:0]               in_src1_val, in_src2_val;
  logic [ROB_ENTRY_NUM-1:0]              rob_valid, rob_ready;
  logic [ROB_ENTRY_NUM*COMMON_WIDTH-1:0] rob_val;
  logic [TAG_WIDTH-1:0]                  res_target;
  logic [COMMON_WIDTH-1:0]               res_result;
  logic                                  issue_valid, issue_ready;
  logic [OP_WIDTH-1:0]                   issue_op;
  logic [COMMON_WIDTH-1:0]               issue_a, issue_b;
  logic [TAG_WIDTH-1:0]                  issue_tag;
  logic [CNT_WIDTH-1:0]                  count;

  int checks = 0;
  int errors = 0;

  alu_rs dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_tag(in_tag), .in_src1_tag(in_src1_tag),
    .in_src2_tag(in_src2_tag), .in_src1_val(in_src1_val),
    .in_src2_val(in_src2_val), .rob_valid(rob_valid),
    .rob_ready(rob_ready), .rob_val(rob_val),
    .res_target(res_target), .res_result(res_result),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_op(issue_op), .issue_a(issue_a), .issue_b(issue_b),
    .issue_tag(issue_tag), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tg, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tg, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [5:0] op, input logic [3:0] t,
                       input logic [3:0] t1, input logic [31:0] v1,
                       input logic [3:0] t2, input logic [31:0] v2);
    in_valid    = 1'b1;
    in_op       = op;
    in_tag      = t;
    in_src1_tag = t1;
    in_src1_val = v1;
    in_src2_tag = t2;
    in_src2_val = v2;
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_op = '0;
    in_tag = '0; in_src1_tag = TAG_INVALID; in_src2_tag = TAG_INVALID;
    in_src1_val = '0; in_src2_val = '0;
    rob_valid = '0; rob_ready = '0; rob_val = '0;
    res_target = TAG_INVALID; res_result = '0; issue_ready = 1'b1;
    #12;
    chk("rst_count", 32'(count), 0);
    chk("rst_ivalid", 32'(issue_valid), 0);
    chk("rst_itag", 32'(issue_tag), 32'hF);
    chk("rst_ia", issue_a, 0);
    rst = 1'b1;
    #1;
    chk("rst_inready", 32'(in_ready), 1);

    // Both operands present at accept
    offer(6'd1, 4'd3, TAG_INVALID, 32'd5, TAG_INVALID, 32'd7);
    step();
    in_valid = 1'b0;
    chk("add_cnt1", 32'(count), 1);
    chk("add_iv0", 32'(issue_valid), 0);
    step();
    chk("add_iv1", 32'(issue_valid), 1);
    chk("add_a", issue_a, 5);
    chk("add_b", issue_b, 7);
    chk("add_tag", 32'(issue_tag), 3);
    chk("add_op", 32'(issue_op), 1);
    chk("add_cnt0", 32'(count), 0);
    step();
    chk("add_drain", 32'(issue_valid), 0);

    // Wakeup from the result bus
    offer(6'd2, 4'd2, 4'd1, 32'hDEAD, TAG_INVALID, 32'd3);
    step();
    in_valid = 1'b0;
    chk("res_cnt", 32'(count), 1);
    step();
    chk("res_pend", 32'(issue_valid), 0);
    res_target = 4'd1; res_result = 32'h10;
    step();
    res_target = TAG_INVALID;
    chk("res_notyet", 32'(issue_valid), 0);
    step();
    chk("res_iv", 32'(issue_valid), 1);
    chk("res_a", issue_a, 32'h10);
    chk("res_b", issue_b, 3);
    chk("res_tag", 32'(issue_tag), 2);
    step();

    // Wakeup from the ROB broadcast
    offer(6'd2, 4'd4, 4'd1, 32'hDEAD, TAG_INVALID, 32'd9);
    step();
    in_valid = 1'b0;
    rob_valid[1] = 1'b1; rob_ready[1] = 1'b1;
    rob_val[1*COMMON_WIDTH +: COMMON_WIDTH] = 32'h22;
    step();
    rob_valid = '0; rob_ready = '0; rob_val = '0;
    chk("rob_notyet", 32'(issue_valid), 0);
    step();
    chk("rob_iv", 32'(issue_valid), 1);
    chk("rob_a", issue_a, 32'h22);
    chk("rob_tag", 32'(issue_tag), 4);
    step();

    // Fill with pending entries, wake the third one only
    for (int i = 0; i < 4; i++) begin
      offer(6'd3, 4'(4 + i), 4'(i), 32'h0, TAG_INVALID, 32'(i));
      step();
    end
    in_valid = 1'b0;
    chk("full_cnt", 32'(count), 4);
    chk("full_inready", 32'(in_ready), 0);
    res_target = 4'd2; res_result = 32'h99;
    step();
    res_target = TAG_INVALID;
    chk("full_inready_rdy", 32'(in_ready), 0);
    chk("full_iv0", 32'(issue_valid), 0);
    step();
    chk("sel_iv", 32'(issue_valid), 1);
    chk("sel_tag", 32'(issue_tag), 6);
    chk("sel_a", issue_a, 32'h99);
    chk("sel_b", issue_b, 2);
    chk("sel_cnt", 32'(count), 3);
    chk("sel_inready", 32'(in_ready), 1);

    // Flush with three entries and a live issue; accept dropped
    flush = 1'b1;
    offer(6'd4, 4'd1, TAG_INVALID, 32'd1, TAG_INVALID, 32'd1);
    #1;
    chk("flush_inready", 32'(in_ready), 0);
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_cnt", 32'(count), 0);
    chk("flush_iv", 32'(issue_valid), 0);
    step();
    chk("flush_drop", 32'(count), 0);
    chk("flush_drop_iv", 32'(issue_valid), 0);

    // Stall: outputs hold, then oldest first
    issue_ready = 1'b0;
    offer(6'd5, 4'd1, TAG_INVALID, 32'h11, TAG_INVALID, 32'd1);
    step();
    offer(6'd6, 4'd2, TAG_INVALID, 32'h22, TAG_INVALID, 32'd2);
    step();
    in_valid = 1'b0;
    chk("hold_cnt", 32'(count), 1);
    for (int i = 0; i < 3; i++) begin
      chk("hold_iv", 32'(issue_valid), 1);
      chk("hold_tag", 32'(issue_tag), 1);
      chk("hold_a", issue_a, 32'h11);
      chk("hold_op", 32'(issue_op), 5);
      if (i < 2) step();
    end
    issue_ready = 1'b1;
    step();
    chk("hold_next_tag", 32'(issue_tag), 2);
    chk("hold_next_a", issue_a, 32'h22);
    chk("hold_next_cnt", 32'(count), 0);
    step();
    chk("hold_drain", 32'(issue_valid), 0);

    // Result bus matches the incoming tag during accept
    offer(6'd7, 4'd5, 4'd3, 32'h0, TAG_INVALID, 32'd4);
    res_target = 4'd3; res_result = 32'h77;
    step();
    in_valid = 1'b0; res_target = TAG_INVALID;
    chk("bypass_iv0", 32'(issue_valid), 0);
    step();
    chk("bypass_iv", 32'(issue_valid), 1);
    chk("bypass_a", issue_a, 32'h77);
    chk("bypass_tag", 32'(issue_tag), 5);
    step();

    // Both operands wait on the same tag
    offer(6'd8, 4'd6, 4'd4, 32'h0, 4'd4, 32'h0);
    step();
    in_valid = 1'b0;
    res_target = 4'd4; res_result = 32'h44;
    step();
    res_target = TAG_INVALID;
    step();
    chk("same_iv", 32'(issue_valid), 1);
    chk("same_a", issue_a, 32'h44);
    chk("same_b", issue_b, 32'h44);
    step();

    // Asynchronous reset while issuing
    offer(6'd9, 4'd7, TAG_INVALID, 32'd1, TAG_INVALID, 32'd2);
    step();
    offer(6'd9, 4'd6, 4'd0, 32'd0, TAG_INVALID, 32'd2);
    step();
    in_valid = 1'b0;
    chk("arst_pre_iv", 32'(issue_valid), 1);
    chk("arst_pre_cnt", 32'(count), 1);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_iv", 32'(issue_valid), 0);
    chk("arst_cnt", 32'(count), 0);
    chk("arst_tag", 32'(issue_tag), 32'hF);
    #1;
    rst = 1'b1;
    step();
    chk("arst_after_cnt", 32'(count), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
